// File: rtl/hamming_pkg.sv
// -----------------------------------------------------------------------------
// hamming_pkg
//
// Shared constants and types for the hamming16 population-count unit.
//
//   HAM_WIDTH     width of the word being counted (16)
//   HAM_CNT_W     width of the bit count, $clog2(HAM_WIDTH+1) (5)
//   NIB_W         nibble width handled by one popcount4 slice (4)
//   NIB_CNT_W     width of a nibble count, holds 0..4 (3)
//   ham_word_t    one input word
//   ham_cnt_t     one full-word bit count, range 0..HAM_WIDTH
//   nib_cnt_t     one nibble bit count, range 0..NIB_W
// -----------------------------------------------------------------------------
package hamming_pkg;

    localparam int HAM_WIDTH = 16;
    localparam int HAM_CNT_W = 5;

    localparam int NIB_W     = 4;
    localparam int NIB_CNT_W = 3;

    typedef logic [HAM_WIDTH-1:0] ham_word_t;
    typedef logic [HAM_CNT_W-1:0] ham_cnt_t;
    typedef logic [NIB_CNT_W-1:0] nib_cnt_t;

endpackage : hamming_pkg

// File: rtl/hamming16_popcount4.sv
// -----------------------------------------------------------------------------
// popcount4
//
// Purely combinational 4-bit population count, used as the stage-1 slice of
// hamming16 (one instance per nibble).
//
// Ports:
//   nibble  in   4  bits to count
//   cnt     out  3  number of set bits in nibble, range 0..4
// -----------------------------------------------------------------------------
module popcount4
    import hamming_pkg::*;
(
    input  logic [NIB_W-1:0] nibble,
    output nib_cnt_t         cnt
);

    // Each bit is widened to the result width before adding, so the sum of
    // four ones (4) never wraps inside a 1- or 2-bit intermediate.
    always_comb begin
        cnt = nib_cnt_t'(nibble[0])
            + nib_cnt_t'(nibble[1])
            + nib_cnt_t'(nibble[2])
            + nib_cnt_t'(nibble[3]);
    end

endmodule : popcount4

// File: rtl/hamming16.sv
// -----------------------------------------------------------------------------
// hamming16
//
// Two-stage pipelined population count (Hamming weight) of a WIDTH-bit word.
//
//   stage 1: the word is split into WIDTH/4 nibbles; each nibble's bit count
//            (0..4) is registered, together with in_valid.
//   stage 2: the nibble counts are summed at full output width and registered
//            into count, together with the stage-1 valid.
//
// A word sampled on clock edge N is reported on count after edge N+2. The
// pipeline advances every cycle regardless of in_valid; consumers qualify
// count with out_valid.
//
// Parameters:
//   WIDTH   input word width, a positive multiple of 4 (default 16)
//   CNT_W   output count width, $clog2(WIDTH+1); derived, not overridable
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset; clears all stages
//   in_valid   in   1      x carries a word this cycle
//   x          in   WIDTH  word whose set bits are counted
//   out_valid  out  1      count belongs to a word accepted 2 cycles earlier
//   count      out  CNT_W  number of ones in that word, range 0..WIDTH
// -----------------------------------------------------------------------------
module hamming16
    import hamming_pkg::*;
#(
    parameter  int WIDTH = HAM_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    output logic             out_valid,
    output logic [CNT_W-1:0] count
);

    localparam int NIBBLES = WIDTH / NIB_W;

    // -------------------------------------------------------------------------
    // Stage 1: per-nibble counts
    // -------------------------------------------------------------------------
    nib_cnt_t nib_cnt_d [NIBBLES];
    nib_cnt_t nib_cnt_q [NIBBLES];
    logic     v1;

    for (genvar g = 0; g < NIBBLES; g++) begin : g_nibble
        popcount4 u_popcount4 (
            .nibble (x[g*NIB_W +: NIB_W]),
            .cnt    (nib_cnt_d[g])
        );
    end

    // NOTE: these registers are a short pipeline, not a memory, so every
    // entry is cleared on reset; that keeps count at 0 (never X) right after
    // reset even though stage 2 adds up whatever stage 1 holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NIBBLES; i++) begin
                nib_cnt_q[i] <= '0;
            end
            v1 <= 1'b0;
        end else begin
            for (int i = 0; i < NIBBLES; i++) begin
                nib_cnt_q[i] <= nib_cnt_d[i];
            end
            v1 <= in_valid;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2: adder tree over the nibble counts
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] sum_d;

    // NOTE: the accumulator is a running combinational value, so it uses
    // blocking assignments and is given a default first; a missing default
    // here would infer a latch.
    // Each nibble count is widened to CNT_W before it is added, so an all-ones
    // word produces exactly WIDTH with no wrap in any narrower intermediate.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            sum_d = sum_d + CNT_W'(nib_cnt_q[i]);
        end
    end

    // NOTE: clocked state is always written with non-blocking assignments so
    // both stages sample their inputs from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            count     <= sum_d;
            out_valid <= v1;
        end
    end

endmodule : hamming16

// File: tb/tb_hamming16.sv
// -----------------------------------------------------------------------------
// tb_hamming16
//
// Self-checking bench for hamming16. Inputs are driven and outputs sampled on
// the falling clock edge. A reference queue holds the expected
// {out_valid, count} for the two words in flight; the expected count is a
// plain bit-by-bit tally of the driven word.
// -----------------------------------------------------------------------------
module tb_hamming16;

    typedef struct packed {
        logic       v;
        logic [4:0] c;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] x;
    logic        out_valid;
    logic [4:0]  count;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t hist[$];

    hamming16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .x         (x),
        .out_valid (out_valid),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends on its own.
    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    function automatic int ref_pop(logic [15:0] w);
        int n = 0;
        for (int b = 0; b < 16; b++) begin
            if (w[b]) n++;
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Direct check of the outputs at the current sampling point.
    task automatic lit(input string tag, input logic v, input logic [4:0] c);
        check({tag, "_valid"}, {15'd0, out_valid}, {15'd0, v});
        check({tag, "_count"}, {11'd0, count}, {11'd0, c});
    endtask

    // Pipeline state is "empty": nothing valid, count 0.
    task automatic model_clear();
        hist.delete();
        hist.push_back('0);
        hist.push_back('0);
    endtask

    // One clock cycle: at the falling edge compare the outputs with the word
    // driven two cycles earlier, then drive the next word.
    task automatic cycle(input logic v, input logic [15:0] d);
        exp_t e;
        exp_t n;
        @(negedge clk);
        e = hist.pop_front();
        check("model_valid", {15'd0, out_valid}, {15'd0, e.v});
        check("model_count", {11'd0, count}, {11'd0, e.c});
        in_valid = v;
        x        = d;
        n.v = v;
        n.c = 5'(ref_pop(d));
        if (!rst_n) n = '0;
        hist.push_back(n);
    endtask

    // Assert reset between edges, confirm the outputs clear before the next
    // edge, hold for n cycles with a valid all-ones word, then release just
    // after a rising edge.
    task automatic apply_reset(input int n);
        exp_t e;
        @(negedge clk);
        e = hist.pop_front();
        check("pre_rst_valid", {15'd0, out_valid}, {15'd0, e.v});
        check("pre_rst_count", {11'd0, count}, {11'd0, e.c});
        rst_n    = 1'b0;
        in_valid = 1'b1;
        x        = 16'hFFFF;
        #1;
        lit("async_rst", 1'b0, 5'd0);
        model_clear();
        for (int i = 0; i < n; i++) cycle(1'b1, 16'hFFFF);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        x        = 16'hFFFF;
        model_clear();

        // Reset held with valid all-ones input: outputs stay zero.
        #1;
        lit("rst_t0", 1'b0, 5'd0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 16'hFFFF);
        lit("rst_hold", 1'b0, 5'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Spot checks and full-scale boundary.
        cycle(1'b1, 16'h0000);
        cycle(1'b1, 16'h0001);
        cycle(1'b1, 16'h8000);  lit("spot_0000", 1'b1, 5'd0);
        cycle(1'b1, 16'hA5A5);  lit("spot_0001", 1'b1, 5'd1);
        cycle(1'b1, 16'hFFFE);  lit("spot_8000", 1'b1, 5'd1);
        cycle(1'b1, 16'hFFFF);  lit("spot_A5A5", 1'b1, 5'd8);
        cycle(1'b0, 16'h0000);  lit("spot_FFFE", 1'b1, 5'd15);
        cycle(1'b0, 16'h0000);  lit("full_FFFF", 1'b1, 5'd16);

        // Valid gating: pattern 1,0,1,1,0.
        cycle(1'b1, 16'h000F);
        cycle(1'b0, 16'h1234);
        cycle(1'b1, 16'h00FF);  lit("gate0", 1'b1, 5'd4);
        cycle(1'b1, 16'hF0F0);  lit("gate1", 1'b0, 5'd5);
        cycle(1'b0, 16'h0000);  lit("gate2", 1'b1, 5'd8);
        cycle(1'b0, 16'h0000);  lit("gate3", 1'b1, 5'd8);
        cycle(1'b0, 16'h0000);  lit("gate4", 1'b0, 5'd0);

        // Back-to-back alternation 0000 / FFFF.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, (i % 2) ? 16'hFFFF : 16'h0000);
            if (i >= 2) lit("b2b", 1'b1, ((i - 2) % 2) ? 5'd16 : 5'd0);
        end

        // Mid-stream reset with three valid words in flight.
        cycle(1'b1, 16'h7777);
        cycle(1'b1, 16'h1111);
        cycle(1'b1, 16'hF00F);
        apply_reset(2);
        cycle(1'b0, 16'hFFFF);  lit("post_rst0", 1'b0, 5'd0);
        cycle(1'b1, 16'h0003);  lit("post_rst1", 1'b0, 5'd0);
        cycle(1'b0, 16'h0000);  lit("post_rst2", 1'b0, 5'd16);
        cycle(1'b0, 16'h0000);  lit("post_rst3", 1'b1, 5'd2);

        // Exhaustive sweep, one word per cycle.
        for (int i = 0; i < 65536; i++) cycle(1'b1, 16'(i));

        // Random words and valids, with occasional random mid-stream resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                apply_reset(int'($urandom_range(1, 3)));
            end else begin
                cycle(1'($urandom_range(0, 1)), 16'($urandom));
            end
        end

        // Drain the pipeline.
        cycle(1'b0, 16'h0000);
        cycle(1'b0, 16'h0000);
        cycle(1'b0, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_hamming16

// File: doc/hamming16.md
Name: hamming16

Overview:
- Pipelined population-count (Hamming weight) unit: reports the number of set bits in a 16-bit input word.
- Sits in datapath checkers / ECC helpers wherever a bit-count of a word is needed.
- Two-stage registered pipeline with a valid flag.
- One clock; asynchronous active-low reset.

Parameters:
- WIDTH, 16, input word width; must be a positive multiple of 4. Only 16 is required to be verified.
- CNT_W, $clog2(WIDTH+1) (=5), output count width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  x is valid this cycle.
- x  input  WIDTH  word whose set bits are counted.
- out_valid  output  1  count holds the result for the word accepted 2 cycles earlier.
- count  output  CNT_W  number of 1 bits in the corresponding x; range 0..WIDTH.

Behaviour:
- Reset (rst_n low, asynchronous assert; deassert synchronised by the system):
  - all pipeline registers clear.
  - out_valid=0, count=0, immediately and held while rst_n is low.
- Stage 1, every rising edge:
  - split x into WIDTH/4 nibbles.
  - register each nibble's popcount as a 3-bit value (0..4).
  - register in_valid into v1.
- Stage 2, every rising edge:
  - sum the nibble counts into CNT_W bits; no truncation anywhere, so x=all-ones gives exactly WIDTH.
  - register the sum into count and v1 into out_valid.
- Latency and throughput:
  - latency exactly 2 clk cycles: x sampled at edge N appears on count after edge N+2.
  - one new word per cycle; no back-pressure, no stall input.
- Pipeline advances unconditionally:
  - stages load even when in_valid=0; count then reflects whatever x was.
  - consumers qualify count with out_valid.
- Mid-stream reset: asserting rst_n discards all in-flight words. The first out_valid after release is 2 cycles after the first in_valid sampled high post-reset.
- Purely unsigned arithmetic; no X propagation from reset state.

Decomposition:
- Shared package hamming_pkg:
  - constant HAM_WIDTH=16.
  - constant HAM_CNT_W=5.
  - typedef ham_word_t (logic[15:0]).
  - typedef ham_cnt_t (logic[4:0]).
- One sub-module: popcount4 (combinational, 4-bit in, 3-bit out), instantiated WIDTH/4 times in stage 1.
- Stage-2 adder tree and valid pipeline live in the top module.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1, x=16'hFFFF -> out_valid=0, count=0 throughout. Assert rst_n mid-stream -> outputs clear asynchronously before the next edge.
- Exhaustive sweep: x=0..16'hFFFF, in_valid=1 every cycle -> each count equals the reference bit-count 2 cycles later. Spot checks:
  - x=16'h0000 -> 0.
  - x=16'h0001 -> 1.
  - x=16'h8000 -> 1.
  - x=16'hA5A5 -> 8.
  - x=16'hFFFE -> 15.
- Full-scale boundary: x=16'hFFFF -> count=16 (5'b10000), confirming no 4-bit wrap.
- Valid gating: in_valid pattern 1,0,1,1,0 with x=16'h000F,16'h1234,16'h00FF,16'hF0F0,16'h0000:
  - out_valid 1,0,1,1,0, two cycles later.
  - counts 4,8 on the valid beats, then 8.
- Back-to-back throughput: alternate x=16'h0000 / 16'hFFFF every cycle -> count alternates 0/16 each cycle after a 2-cycle delay.
- Reset mid-stream: 3 valid words in flight, pulse rst_n low -> no out_valid for any pre-reset word. Post-reset word x=16'h0003 -> out_valid with count=2 two cycles later.
